// File: rtl/dii_package.sv
// Shared debug-interconnect flit type used on every ring port.
package dii_package;

    localparam int unsigned DII_DATA_W = 16;

    // One ring flit: handshake valid, end-of-packet marker and payload.
    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;

endpackage

// File: rtl/dii_flit_fifo.sv
// Flit FIFO for the ring-0 to ring-1 wrap path.
// The output is driven from the head entry, so there is at least one cycle of latency.
// When the FIFO is full, a pop in the same cycle does not free a slot for a push.
module dii_flit_fifo
    import dii_package::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  dii_flit i_flit,
    output logic    o_flit_ready,
    output dii_flit o_flit,
    input  logic    i_flit_ready
);

    localparam int unsigned PTR_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned CNT_W   = $clog2(SIZE) + 1;
    localparam int unsigned ENTRY_W = DII_DATA_W + 1;

    logic [ENTRY_W-1:0] r_mem [SIZE];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(SIZE));
    assign w_empty = (r_count == '0);

    // Never accept during reset; the full test uses occupancy only, so there is no pop-through.
    assign o_flit_ready = !w_full && !rst;
    assign w_push       = i_flit.valid && o_flit_ready;
    assign w_pop        = !w_empty && i_flit_ready;

    // Head entry presented as a flit; valid is the non-empty flag.
    always_comb begin
        o_flit       = '0;
        o_flit.valid = !w_empty;
        o_flit.last  = r_mem[r_rd_ptr][DII_DATA_W];
        o_flit.data  = r_mem[r_rd_ptr][DII_DATA_W-1:0];
    end

    // Storage write; SIZE is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {i_flit.last, i_flit.data};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer advance on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy tracking; a simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/debug_ring_terminate.sv
// Terminates a two-ring debug interconnect.
// Ring-0 traffic is wrapped onto ring 1 through a FIFO. Ring-1 traffic is sunk,
// and dropped packets are counted.
module debug_ring_terminate
    import dii_package::*;
#(
    parameter int unsigned BUFFER_SIZE = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  dii_flit               ring0_tail_in,
    output logic                  ring0_tail_in_ready,
    output dii_flit               ring1_head_out,
    input  logic                  ring1_head_out_ready,
    input  dii_flit               ring1_tail_in,
    output logic                  ring1_tail_in_ready,
    output dii_flit               ring0_head_out,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [DII_DATA_W-1:0] drop_last_dest,
    output logic                  drop_event
);

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } sink_state_e;

    sink_state_e           r_state;
    sink_state_e           w_state_nxt;
    logic [DII_DATA_W-1:0] r_pend_dest;
    logic                  w_pend_load;
    logic                  w_count_pkt;
    logic [DII_DATA_W-1:0] w_dest;
    logic                  w_accept;
    logic [CNT_WIDTH-1:0]  r_drop_count;
    logic [DII_DATA_W-1:0] r_drop_last_dest;
    logic                  r_drop_event;

    // Wrap path from ring 0 to ring 1.
    dii_flit_fifo #(
        .SIZE (BUFFER_SIZE)
    ) u_wrap_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_flit       (ring0_tail_in),
        .o_flit_ready (ring0_tail_in_ready),
        .o_flit       (ring1_head_out),
        .i_flit_ready (ring1_head_out_ready)
    );

    // Nothing is ever injected at the head of ring 0, and ring 1 always drains.
    assign ring0_head_out      = '0;
    assign ring1_tail_in_ready = 1'b1;
    assign w_accept            = ring1_tail_in.valid && ring1_tail_in_ready;

    // Sink FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sink FSM next-state and packet-count decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_load = 1'b0;
        w_count_pkt = 1'b0;
        w_dest      = ring1_tail_in.data;
        if (w_accept) begin
            case (r_state)
                ST_HEAD: begin
                    if (ring1_tail_in.last) begin
                        w_count_pkt = 1'b1;
                    end else begin
                        w_pend_load = 1'b1;
                        w_state_nxt = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (ring1_tail_in.last) begin
                        w_count_pkt = 1'b1;
                        w_dest      = r_pend_dest;
                        w_state_nxt = ST_HEAD;
                    end
                end
                default: w_state_nxt = ST_HEAD;
            endcase
        end
    end

    // Hold the destination flit of a multi-flit packet until its tail arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_dest <= '0;
        end else if (w_pend_load) begin
            r_pend_dest <= ring1_tail_in.data;
        end
    end

    // Drop statistics, one cycle after the packet tail; the counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count     <= '0;
            r_drop_last_dest <= '0;
            r_drop_event     <= 1'b0;
        end else begin
            r_drop_event <= w_count_pkt;
            if (w_count_pkt) begin
                r_drop_last_dest <= w_dest;
                if (r_drop_count != {CNT_WIDTH{1'b1}}) begin
                    r_drop_count <= r_drop_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign drop_count     = r_drop_count;
    assign drop_last_dest = r_drop_last_dest;
    assign drop_event     = r_drop_event;

endmodule

// File: tb/tb_debug_ring_terminate.sv
// Randomized and directed bench for debug_ring_terminate, checked against a queue/packet-level model.
module tb_debug_ring_terminate;
    import dii_package::*;

    localparam int unsigned BS = 4;

    logic    clk = 1'b0;
    logic    rst;
    dii_flit r0_in;
    logic    r0_rdy;
    dii_flit r1_head;
    logic    r1h_rdy;
    dii_flit r1_tail;
    logic    r1t_rdy;
    dii_flit r0_head;
    logic [15:0] d_cnt;
    logic [15:0] d_dest;
    logic        d_ev;

    dii_flit     zero_flit;
    logic        s_r0_rdy;
    dii_flit     s_r1_head;
    logic        s_r1t_rdy;
    dii_flit     s_r0_head;
    logic [3:0]  s_cnt;
    logic [15:0] s_dest;
    logic        s_ev;

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    dii_flit     q[$];
    logic [15:0] pkt[$];
    int          m_cnt, m_cnt_sat;
    logic [15:0] m_dest;
    bit          m_ev;
    bit          m_acc0;

    always #5 clk = ~clk;

    debug_ring_terminate #(.BUFFER_SIZE(BS), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .ring0_tail_in(r0_in), .ring0_tail_in_ready(r0_rdy),
        .ring1_head_out(r1_head), .ring1_head_out_ready(r1h_rdy),
        .ring1_tail_in(r1_tail), .ring1_tail_in_ready(r1t_rdy),
        .ring0_head_out(r0_head),
        .drop_count(d_cnt), .drop_last_dest(d_dest), .drop_event(d_ev)
    );

    debug_ring_terminate #(.BUFFER_SIZE(BS), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .ring0_tail_in(zero_flit), .ring0_tail_in_ready(s_r0_rdy),
        .ring1_head_out(s_r1_head), .ring1_head_out_ready(1'b1),
        .ring1_tail_in(r1_tail), .ring1_tail_in_ready(s_r1t_rdy),
        .ring0_head_out(s_r0_head),
        .drop_count(s_cnt), .drop_last_dest(s_dest), .drop_event(s_ev)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic dii_flit mk(input bit v, input bit l, input logic [15:0] d);
        dii_flit f;
        f.valid = v;
        f.last  = l;
        f.data  = d;
        return f;
    endfunction

    task automatic model_reset();
        q.delete();
        pkt.delete();
        m_cnt     = 0;
        m_cnt_sat = 0;
        m_dest    = '0;
        m_ev      = 1'b0;
    endtask

    // Drive one cycle of inputs, check the outputs against the model, then advance the model and the clock.
    task automatic cycle(input bit rv, input dii_flit a, input bit b, input dii_flit c);
        bit exp_rdy;
        bit push;
        bit pop;
        rst     = rv;
        r0_in   = a;
        r1h_rdy = b;
        r1_tail = c;
        #1;
        exp_rdy = !rv && (q.size() < int'(BS));
        chk("r0_tail_ready", 32'(r0_rdy), 32'(exp_rdy));
        chk("r1_head_valid", 32'(r1_head.valid), 32'(q.size() > 0));
        if (q.size() > 0)
            chk("r1_head_flit", 32'({r1_head.last, r1_head.data}), 32'({q[0].last, q[0].data}));
        chk("r1_tail_ready", 32'({r1t_rdy, s_r1t_rdy}), 32'(2'b11));
        chk("r0_head_idle", 32'(r0_head), 32'(0));
        chk("drop_count", 32'(d_cnt), 32'(m_cnt));
        chk("drop_dest", 32'(d_dest), 32'(m_dest));
        chk("drop_event", 32'(d_ev), 32'(m_ev));
        chk("sat_count", 32'(s_cnt), 32'(m_cnt_sat));
        chk("sat_event", 32'({s_ev, s_dest}), 32'({m_ev, m_dest}));

        push   = a.valid && exp_rdy;
        pop    = (q.size() > 0) && b;
        m_acc0 = push;
        if (rv) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(a);
            m_ev = 1'b0;
            if (c.valid) begin
                pkt.push_back(c.data);
                if (c.last) begin
                    m_dest    = pkt[0];
                    m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    m_cnt_sat = (m_cnt_sat < 15) ? m_cnt_sat + 1 : 15;
                    m_ev      = 1'b1;
                    pkt.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit b);
        for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0, 0), b, mk(0, 0, 0));
    endtask

    task automatic do_reset();
        cycle(1'b1, mk(0, 0, 0), 1'b0, mk(0, 0, 0));
        cycle(1'b1, mk(0, 0, 0), 1'b0, mk(0, 0, 0));
    endtask

    dii_flit seq[6];
    int      idx;

    initial begin
        zero_flit = '0;
        rst       = 1'b1;
        r0_in     = '0;
        r1h_rdy   = 1'b0;
        r1_tail   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(d_cnt), 32'(0));
        chk("reset_valid", 32'(r1_head.valid), 32'(0));
        do_reset();

        // Three-flit wrap with one cycle of latency.
        cycle(1'b0, mk(1, 0, 16'h0005), 1'b1, mk(0, 0, 0));
        chk("wrap_first_latency", 32'({r1_head.valid, r1_head.data}), 32'({1'b1, 16'h0005}));
        cycle(1'b0, mk(1, 0, 16'h1234), 1'b1, mk(0, 0, 0));
        cycle(1'b0, mk(1, 1, 16'hABCD), 1'b1, mk(0, 0, 0));
        idle(4, 1'b1);

        // Backpressure: four fill the FIFO, two wait until ring 1 resumes.
        for (int i = 0; i < 6; i++) seq[i] = mk(1, (i == 5), 16'(16'h0100 + i));
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, seq[idx], 1'b0, mk(0, 0, 0));
            if (m_acc0) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'(4));
        chk("bp_full_ready", 32'(r0_rdy), 32'(0));
        for (int i = 0; i < 20 && idx < 6; i++) begin
            cycle(1'b0, seq[idx], 1'b1, mk(0, 0, 0));
            if (m_acc0) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'(6));
        idle(8, 1'b1);

        // Two dropped packets on ring 1.
        do_reset();
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 16'h0003));
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 16'h1111));
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 1, 16'h2222));
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 1, 16'h0007));
        idle(2, 1'b1);
        chk("drop2_count", 32'(d_cnt), 32'(2));
        chk("drop2_dest", 32'(d_dest), 32'(16'h0007));

        // Saturation of the 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 1, 16'(i)));
        idle(1, 1'b1);
        chk("sat_hold", 32'(s_cnt), 32'(4'hF));
        chk("sat_wide", 32'(d_cnt), 32'(17));

        // Reset in the middle of packets on both paths.
        do_reset();
        cycle(1'b0, mk(1, 0, 16'hAAAA), 1'b0, mk(1, 0, 16'h00EE));
        cycle(1'b0, mk(1, 0, 16'hBBBB), 1'b0, mk(1, 0, 16'h00FF));
        cycle(1'b1, mk(0, 0, 0), 1'b0, mk(0, 0, 0));
        chk("mid_rst_valid", 32'(r1_head.valid), 32'(0));
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 16'h0042));
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 16'h0001));
        cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 1, 16'h0002));
        idle(1, 1'b1);
        chk("mid_rst_count", 32'(d_cnt), 32'(1));
        chk("mid_rst_dest", 32'(d_dest), 32'(16'h0042));

        // Random concurrent traffic with occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  mk(($urandom_range(0, 9) < 6), 1'($urandom), 16'($urandom)),
                  1'($urandom),
                  mk(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0), 16'($urandom)));
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
